// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
// Shared types and constants for the two-requester memory arbiter.
//   requester_t     : identifies requester 0 (rv32i core) or requester 1 (loader/DMA)
//   NUM_REQUESTERS  : number of bus masters sharing the memory
//   other_requester : returns the requester that is not the argument
package memory_arbiter_pkg;

   typedef enum logic {
      REQ_0 = 1'b0,
      REQ_1 = 1'b1
   } requester_t;

   localparam int NUM_REQUESTERS = 2;

   function automatic requester_t other_requester(input requester_t r);
      return (r == REQ_0) ? REQ_1 : REQ_0;
   endfunction

endpackage

// File: rtl/register.sv
// register
// Generic codebase flop with synchronous active-high reset and load enable.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, loads RESET_VAL
//   en   : load enable, q holds when low
//   d    : next value
//   q    : registered value
module register #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/round_robin_picker.sv
// round_robin_picker
// Purely combinational winner selection between two requesters. A lone
// requester always wins; on a tie the requester that did not win last time
// is chosen, so continuously contending masters alternate.
// Ports:
//   req        : request vector, already qualified by enable/reset
//   last_gnt   : index of the most recent winner
//   gnt_onehot : one-hot grant, all zero when nobody requests
//   winner     : index of the winner (REQ_0 when nobody requests)
//   any_gnt    : high when some requester won this cycle
module round_robin_picker
   import memory_arbiter_pkg::*;
(
   input  logic [NUM_REQUESTERS-1:0] req,
   input  requester_t                last_gnt,
   output logic [NUM_REQUESTERS-1:0] gnt_onehot,
   output requester_t                winner,
   output logic                      any_gnt
);

   always_comb begin
      gnt_onehot = '0;
      winner     = REQ_0;
      any_gnt    = 1'b0;
      case (req)
         2'b01: begin
            winner  = REQ_0;
            any_gnt = 1'b1;
         end
         2'b10: begin
            winner  = REQ_1;
            any_gnt = 1'b1;
         end
         2'b11: begin
            winner  = other_requester(last_gnt);
            any_gnt = 1'b1;
         end
         default: begin
            winner  = REQ_0;
            any_gnt = 1'b0;
         end
      endcase
      if (any_gnt) begin
         gnt_onehot[winner] = 1'b1;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one single-ported synchronous memory between the rv32i multicycle
// core (requester 0) and a second bus master (requester 1). At most one
// access is issued per cycle, round-robin on conflict. Read data returns one
// cycle after the grant with a per-requester valid strobe.
//
// Optional feature: define MEMORY_ARBITER_STATS_EN to add per-requester
// saturating stall counters (stall_cnt0/stall_cnt1).
//
// Ports:
//   clk, rst              : clock (rising edge), synchronous active-high reset
//   ena                   : global enable, no grants and arbitration state held when low
//   reqN/addrN/wr_dataN/wr_enaN : request from requester N, held until granted
//   gntN                  : combinational grant, high in the cycle the access is issued
//   rd_dataN, rd_validN   : read response, valid one cycle after a read grant
//   mem_addr/mem_wr_data/mem_wr_ena : memory drive from the winner, zero when idle
//   mem_rd_data           : memory read data, one cycle after the address
//   stall_cntN            : (stats build only) cycles requester N waited while enabled
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              wr_ena0,
   input  logic              wr_ena1,
   output logic              gnt0,
   output logic              gnt1,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   output logic              rd_valid0,
   output logic              rd_valid1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_wr_ena,
`ifdef MEMORY_ARBITER_STATS_EN
   output logic [31:0]       stall_cnt0,
   output logic [31:0]       stall_cnt1,
`endif
   input  logic [DATA_W-1:0] mem_rd_data
);

   logic [NUM_REQUESTERS-1:0] req_qual;
   logic [NUM_REQUESTERS-1:0] gnt_onehot;
   requester_t                winner;
   logic                      any_gnt;

   logic [0:0] last_gnt_d, last_gnt_q;
   logic [0:0] resp_valid_d, resp_valid_q;
   logic [0:0] resp_id_d, resp_id_q;
   requester_t last_gnt;
   requester_t resp_id;

   assign last_gnt = requester_t'(last_gnt_q);
   assign resp_id  = requester_t'(resp_id_q);

   // Requests are masked while disabled or in reset so nothing is granted
   // and the round-robin pointer cannot move.
   assign req_qual = {req1, req0} & {NUM_REQUESTERS{ena & ~rst}};

   round_robin_picker u_picker (
      .req        (req_qual),
      .last_gnt   (last_gnt),
      .gnt_onehot (gnt_onehot),
      .winner     (winner),
      .any_gnt    (any_gnt)
   );

   assign gnt0 = gnt_onehot[0];
   assign gnt1 = gnt_onehot[1];

   // Memory drive: the winner's request goes out, an idle cycle drives zeros
   // so the write enable can never be high without a grant.
   always_comb begin
      mem_addr    = '0;
      mem_wr_data = '0;
      mem_wr_ena  = 1'b0;
      if (gnt0) begin
         mem_addr    = addr0;
         mem_wr_data = wr_data0;
         mem_wr_ena  = wr_ena0;
      end else if (gnt1) begin
         mem_addr    = addr1;
         mem_wr_data = wr_data1;
         mem_wr_ena  = wr_ena1;
      end
   end

   // Next-state for arbitration and the one-entry response pipeline. Only
   // reads produce a response; writes commit at the edge ending the grant.
   always_comb begin
      last_gnt_d   = last_gnt_q;
      resp_valid_d = 1'b0;
      resp_id_d    = resp_id_q;
      if (any_gnt) begin
         last_gnt_d   = 1'(winner);
         resp_valid_d = ~mem_wr_ena;
         resp_id_d    = 1'(winner);
      end
   end

   // last_gnt resets to requester 1 so requester 0 wins the first tie.
   register #(.WIDTH(1), .RESET_VAL(1'(REQ_1))) u_last_gnt (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (last_gnt_d),
      .q   (last_gnt_q)
   );

   register #(.WIDTH(1), .RESET_VAL(1'b0)) u_resp_valid (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (resp_valid_d),
      .q   (resp_valid_q)
   );

   register #(.WIDTH(1), .RESET_VAL(1'(REQ_0))) u_resp_id (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (resp_id_d),
      .q   (resp_id_q)
   );

   // The valid strobe is gated by reset so a read in flight when reset
   // arrives is dropped in that very cycle rather than leaking out.
   assign rd_valid0 = resp_valid_q[0] & ~rst & (resp_id == REQ_0);
   assign rd_valid1 = resp_valid_q[0] & ~rst & (resp_id == REQ_1);
   assign rd_data0  = mem_rd_data;
   assign rd_data1  = mem_rd_data;

`ifdef MEMORY_ARBITER_STATS_EN
   logic [31:0] stall_cnt0_d, stall_cnt0_q;
   logic [31:0] stall_cnt1_d, stall_cnt1_q;

   // A stall is a cycle where the requester is asking, the arbiter is
   // enabled, and someone else won. Counters stick at all-ones.
   always_comb begin
      stall_cnt0_d = stall_cnt0_q;
      stall_cnt1_d = stall_cnt1_q;
      if (ena && req0 && !gnt0 && (stall_cnt0_q != 32'hFFFF_FFFF)) begin
         stall_cnt0_d = stall_cnt0_q + 32'd1;
      end
      if (ena && req1 && !gnt1 && (stall_cnt1_q != 32'hFFFF_FFFF)) begin
         stall_cnt1_d = stall_cnt1_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt0_q <= '0;
         stall_cnt1_q <= '0;
      end else begin
         stall_cnt0_q <= stall_cnt0_d;
         stall_cnt1_q <= stall_cnt1_d;
      end
   end

   assign stall_cnt0 = stall_cnt0_q;
   assign stall_cnt1 = stall_cnt1_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter with a small behavioural synchronous
// memory. Inputs change on the falling edge; outputs are sampled 1 time unit
// later, so each "cycle" below spans exactly one rising edge.
module tb_memory_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk;
   logic              rst;
   logic              ena;
   logic              req0, req1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wr_data0, wr_data1;
   logic              wr_ena0, wr_ena1;
   logic              gnt0, gnt1;
   logic [DATA_W-1:0] rd_data0, rd_data1;
   logic              rd_valid0, rd_valid1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_ena;
   logic [DATA_W-1:0] mem_rd_data;
`ifdef MEMORY_ARBITER_STATS_EN
   logic [31:0]       stall_cnt0, stall_cnt1;
`endif

   int total;
   int bad;

   // Preload port into the behavioural memory, used only while the arbiter is idle.
   logic              pl_en;
   logic [7:0]        pl_addr;
   logic [DATA_W-1:0] pl_data;
   logic [DATA_W-1:0] mem [256];

   memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .req0        (req0),
      .req1        (req1),
      .addr0       (addr0),
      .addr1       (addr1),
      .wr_data0    (wr_data0),
      .wr_data1    (wr_data1),
      .wr_ena0     (wr_ena0),
      .wr_ena1     (wr_ena1),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .rd_data0    (rd_data0),
      .rd_data1    (rd_data1),
      .rd_valid0   (rd_valid0),
      .rd_valid1   (rd_valid1),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_ena  (mem_wr_ena),
`ifdef MEMORY_ARBITER_STATS_EN
      .stall_cnt0  (stall_cnt0),
      .stall_cnt1  (stall_cnt1),
`endif
      .mem_rd_data (mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-ported synchronous memory: write commits and read data appears
   // on the edge that ends the access cycle.
   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (mem_wr_ena) begin
         mem[mem_addr[7:0]] <= mem_wr_data;
      end
      mem_rd_data <= mem[mem_addr[7:0]];
   end

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0;
      addr0 = '0; addr1 = '0;
      wr_data0 = '0; wr_data1 = '0;
      wr_ena0 = 1'b0; wr_ena1 = 1'b0;
   endtask

   // Leaves rst high; the next test's first cycle releases it.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      ena = 1'b1;
      idle_inputs();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; ena = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      addr0 = 32'h44; addr1 = 32'h88;
      wr_data0 = 32'h1111; wr_data1 = 32'h2222;
      wr_ena0 = 1'b1; wr_ena1 = 1'b1;
      @(negedge clk);
      #1;
      total++; if (gnt0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt0 got=%b want=0", gnt0); end
      total++; if (gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt1 got=%b want=0", gnt1); end
      total++; if (rd_valid0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_valid0 got=%b want=0", rd_valid0); end
      total++; if (rd_valid1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_valid1 got=%b want=0", rd_valid1); end
      total++; if (mem_wr_ena !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_wr_ena got=%b want=0", mem_wr_ena); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%h want=0", mem_addr); end
      total++; if (mem_wr_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_wr_data got=%h want=0", mem_wr_data); end
`ifdef MEMORY_ARBITER_STATS_EN
      total++; if (stall_cnt0 !== 32'd0) begin bad++; $display("[TB] FAIL reset_stall0 got=%0d want=0", stall_cnt0); end
      total++; if (stall_cnt1 !== 32'd0) begin bad++; $display("[TB] FAIL reset_stall1 got=%0d want=0", stall_cnt1); end
`endif
      idle_inputs();
   endtask

   task automatic test_single_read();
      do_reset();
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; addr0 = 32'h10; wr_ena0 = 1'b0;
      #1;
      total++; if (gnt0 !== 1'b1) begin bad++; $display("[TB] FAIL single_gnt0 got=%b want=1", gnt0); end
      total++; if (gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL single_gnt1 got=%b want=0", gnt1); end
      total++; if (mem_addr !== 32'h10) begin bad++; $display("[TB] FAIL single_mem_addr got=%h want=10", mem_addr); end
      @(negedge clk);
      req0 = 1'b0;
      #1;
      total++; if (rd_valid0 !== 1'b1) begin bad++; $display("[TB] FAIL single_rd_valid0 got=%b want=1", rd_valid0); end
      total++; if (rd_data0 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_rd_data0 got=%h want=deadbeef", rd_data0); end
      total++; if (rd_valid1 !== 1'b0) begin bad++; $display("[TB] FAIL single_rd_valid1 got=%b want=0", rd_valid1); end
      @(negedge clk);
      #1;
      total++; if (rd_valid0 !== 1'b0) begin bad++; $display("[TB] FAIL single_rd_valid0_pulse got=%b want=0", rd_valid0); end
   endtask

   task automatic test_alternate();
      logic [3:0] exp_g0;
      logic       prev_winner;
      exp_g0 = 4'b0101;
      prev_winner = 1'b0;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         rst = 1'b0;
         req0 = 1'b1; addr0 = 32'h20;
         req1 = 1'b1; addr1 = 32'h30;
         #1;
         total++; if (gnt0 !== exp_g0[c]) begin bad++; $display("[TB] FAIL alt_gnt0[%0d] got=%b want=%b", c, gnt0, exp_g0[c]); end
         total++; if (gnt1 !== ~exp_g0[c]) begin bad++; $display("[TB] FAIL alt_gnt1[%0d] got=%b want=%b", c, gnt1, ~exp_g0[c]); end
         total++; if (mem_addr !== (exp_g0[c] ? 32'h20 : 32'h30)) begin bad++; $display("[TB] FAIL alt_mem_addr[%0d] got=%h want=%h", c, mem_addr, exp_g0[c] ? 32'h20 : 32'h30); end
         if (c > 0) begin
            total++; if (rd_valid0 !== ~prev_winner) begin bad++; $display("[TB] FAIL alt_rd_valid0[%0d] got=%b want=%b", c, rd_valid0, ~prev_winner); end
            total++; if (rd_valid1 !== prev_winner) begin bad++; $display("[TB] FAIL alt_rd_valid1[%0d] got=%b want=%b", c, rd_valid1, prev_winner); end
         end
         prev_winner = ~exp_g0[c];
      end
      @(negedge clk);
      idle_inputs();
      #1;
      total++; if (rd_valid1 !== 1'b1) begin bad++; $display("[TB] FAIL alt_last_rd_valid1 got=%b want=1", rd_valid1); end
      total++; if (rd_valid0 !== 1'b0) begin bad++; $display("[TB] FAIL alt_last_rd_valid0 got=%b want=0", rd_valid0); end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      rst = 1'b0;
      req1 = 1'b1; addr1 = 32'h40; wr_data1 = 32'h12345678; wr_ena1 = 1'b1;
      #1;
      total++; if (gnt1 !== 1'b1) begin bad++; $display("[TB] FAIL wr_gnt1 got=%b want=1", gnt1); end
      total++; if (mem_wr_ena !== 1'b1) begin bad++; $display("[TB] FAIL wr_mem_wr_ena got=%b want=1", mem_wr_ena); end
      total++; if (mem_addr !== 32'h40) begin bad++; $display("[TB] FAIL wr_mem_addr got=%h want=40", mem_addr); end
      total++; if (mem_wr_data !== 32'h12345678) begin bad++; $display("[TB] FAIL wr_mem_wr_data got=%h want=12345678", mem_wr_data); end
      @(negedge clk);
      idle_inputs();
      req0 = 1'b1; addr0 = 32'h40;
      #1;
      total++; if (gnt0 !== 1'b1) begin bad++; $display("[TB] FAIL rd_gnt0 got=%b want=1", gnt0); end
      total++; if (mem_wr_ena !== 1'b0) begin bad++; $display("[TB] FAIL rd_mem_wr_ena got=%b want=0", mem_wr_ena); end
      total++; if (rd_valid1 !== 1'b0) begin bad++; $display("[TB] FAIL wr_no_resp got=%b want=0", rd_valid1); end
      @(negedge clk);
      idle_inputs();
      #1;
      total++; if (rd_valid0 !== 1'b1) begin bad++; $display("[TB] FAIL wrrd_rd_valid0 got=%b want=1", rd_valid0); end
      total++; if (rd_data0 !== 32'h12345678) begin bad++; $display("[TB] FAIL wrrd_rd_data0 got=%h want=12345678", rd_data0); end
      total++; if (rd_valid1 !== 1'b0) begin bad++; $display("[TB] FAIL wrrd_rd_valid1 got=%b want=0", rd_valid1); end
      total++; if (mem_wr_ena !== 1'b0) begin bad++; $display("[TB] FAIL wrrd_mem_wr_ena got=%b want=0", mem_wr_ena); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; addr0 = 32'h10;
      #1;
      total++; if (gnt0 !== 1'b1) begin bad++; $display("[TB] FAIL mid_gnt0 got=%b want=1", gnt0); end
      @(negedge clk);
      rst = 1'b1;
      req1 = 1'b1; addr1 = 32'h30;
      #1;
      total++; if (rd_valid0 !== 1'b0) begin bad++; $display("[TB] FAIL mid_rd_valid0_in_rst got=%b want=0", rd_valid0); end
      total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL mid_gnt_in_rst got=%b%b want=00", gnt1, gnt0); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (rd_valid0 !== 1'b0) begin bad++; $display("[TB] FAIL mid_rd_valid0_after got=%b want=0", rd_valid0); end
      total++; if (gnt0 !== 1'b1) begin bad++; $display("[TB] FAIL mid_tie_gnt0 got=%b want=1", gnt0); end
      total++; if (gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL mid_tie_gnt1 got=%b want=0", gnt1); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_ena_low();
      do_reset();
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; addr0 = 32'h10;
      #1;
      total++; if (gnt0 !== 1'b1) begin bad++; $display("[TB] FAIL ena_pre_gnt0 got=%b want=1", gnt0); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ena = 1'b0;
         req1 = 1'b1; addr1 = 32'h80; wr_data1 = 32'hA5A5A5A5; wr_ena1 = 1'b1;
         #1;
         total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL ena_low_gnt[%0d] got=%b%b want=00", c, gnt1, gnt0); end
         total++; if (mem_wr_ena !== 1'b0) begin bad++; $display("[TB] FAIL ena_low_wr_ena[%0d] got=%b want=0", c, mem_wr_ena); end
         if (c == 0) begin
            total++; if (rd_valid0 !== 1'b1) begin bad++; $display("[TB] FAIL ena_low_inflight got=%b want=1", rd_valid0); end
            total++; if (rd_data0 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL ena_low_inflight_data got=%h want=deadbeef", rd_data0); end
         end else begin
            total++; if (rd_valid0 !== 1'b0) begin bad++; $display("[TB] FAIL ena_low_rd_valid0[%0d] got=%b want=0", c, rd_valid0); end
         end
`ifdef MEMORY_ARBITER_STATS_EN
         total++; if (stall_cnt0 !== 32'd0 || stall_cnt1 !== 32'd0) begin bad++; $display("[TB] FAIL ena_low_stall[%0d] got=%0d/%0d want=0/0", c, stall_cnt0, stall_cnt1); end
`endif
      end
      @(negedge clk);
      ena = 1'b1;
      #1;
      total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin bad++; $display("[TB] FAIL ena_resume1 got=%b%b want=10", gnt1, gnt0); end
      total++; if (mem_wr_ena !== 1'b1) begin bad++; $display("[TB] FAIL ena_resume_wr got=%b want=1", mem_wr_ena); end
      total++; if (mem_addr !== 32'h80) begin bad++; $display("[TB] FAIL ena_resume_addr got=%h want=80", mem_addr); end
      @(negedge clk);
      #1;
      total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL ena_resume2 got=%b%b want=01", gnt1, gnt0); end
      @(negedge clk);
      idle_inputs();
      #1;
`ifdef MEMORY_ARBITER_STATS_EN
      total++; if (stall_cnt0 !== 32'd1) begin bad++; $display("[TB] FAIL ena_stall0 got=%0d want=1", stall_cnt0); end
      total++; if (stall_cnt1 !== 32'd1) begin bad++; $display("[TB] FAIL ena_stall1 got=%0d want=1", stall_cnt1); end
`endif
      total++; if (rd_valid0 !== 1'b1) begin bad++; $display("[TB] FAIL ena_resume_rd_valid0 got=%b want=1", rd_valid0); end
   endtask

`ifdef MEMORY_ARBITER_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         rst = 1'b0;
         req0 = 1'b1; addr0 = 32'h10;
         req1 = 1'b1; addr1 = 32'h40;
         #1;
         if (c == 3) begin
            total++; if (stall_cnt0 !== 32'd1) begin bad++; $display("[TB] FAIL stats_mid0 got=%0d want=1", stall_cnt0); end
            total++; if (stall_cnt1 !== 32'd2) begin bad++; $display("[TB] FAIL stats_mid1 got=%0d want=2", stall_cnt1); end
         end
      end
      @(negedge clk);
      idle_inputs();
      #1;
      total++; if (stall_cnt0 !== 32'd3) begin bad++; $display("[TB] FAIL stats_end0 got=%0d want=3", stall_cnt0); end
      total++; if (stall_cnt1 !== 32'd3) begin bad++; $display("[TB] FAIL stats_end1 got=%0d want=3", stall_cnt1); end
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      ena = 1'b1;
      pl_en = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      idle_inputs();

      test_reset();

      @(negedge clk);
      pl_en = 1'b1; pl_addr = 8'h10; pl_data = 32'hDEADBEEF;
      @(negedge clk);
      pl_en = 1'b0;

      test_single_read();
      test_alternate();
      test_write_read();
      test_reset_midflight();
      test_ena_low();
`ifdef MEMORY_ARBITER_STATS_EN
      test_stats();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
